// File: rtl/dm_boot_loader.sv
// dm_boot_loader: data-memory boot initialiser.
// After reset (AUTO_START=1) or on a start pulse it zeroes words
// 0..CLEAR_WORDS-1, then writes a fixed five-entry constant table, holding
// the CPU off the memory port (cpu_hold) until loading has finished.
// Optional read-back check of the table is enabled by defining the macro
// DM_BOOT_VERIFY_EN; without it the VERIFY/ERROR states do not exist and
// error is tied low.
module dm_boot_loader #(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int CLEAR_WORDS = 20,
  parameter int AUTO_START  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  input  logic [DATA_W-1:0]     rd,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_hold,
  output logic                  error
);

  localparam int NUM_ENTRIES = 5;
  localparam int IDX_MAX     = (CLEAR_WORDS > NUM_ENTRIES) ? CLEAR_WORDS : NUM_ENTRIES;
  localparam int IDX_W       = $clog2(IDX_MAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
`ifdef DM_BOOT_VERIFY_EN
  localparam logic [2:0] S_VERIFY = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;
`endif

  logic [2:0]       state;
  logic [IDX_W-1:0] idx;
  logic             auto_pend;
  logic [31:0]      idx32;
  logic [31:0]      tab_addr;
  logic [31:0]      tab_data;
  logic             clear_last;
  logic             tab_last;

  assign idx32      = 32'(idx);
  assign clear_last = (idx == IDX_W'(CLEAR_WORDS - 1));
  assign tab_last   = (idx == IDX_W'(NUM_ENTRIES - 1));

  // Constant table lookup indexed by idx (addresses truncated at the port).
  always_comb begin
    tab_addr = '0;
    tab_data = '0;
    case (idx32)
      32'd0: begin tab_addr = 32'd4;  tab_data = 32'h0000_0005; end
      32'd1: begin tab_addr = 32'd8;  tab_data = 32'hFFFF_FFF7; end
      32'd2: begin tab_addr = 32'd12; tab_data = 32'h0000_000C; end
      32'd3: begin tab_addr = 32'd13; tab_data = 32'h0000_000E; end
      32'd4: begin tab_addr = 32'd14; tab_data = 32'hFFFF_FFEE; end
      default: begin tab_addr = '0; tab_data = '0; end
    endcase
  end

`ifdef DM_BOOT_VERIFY_EN
  logic err_q;
  assign error = err_q;
`else
  logic rd_unused;
  assign rd_unused = ^rd;
  assign error     = 1'b0;
`endif

  // State, index counter and auto-start flag; reset aborts any sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      auto_pend <= (AUTO_START != 0);
`ifdef DM_BOOT_VERIFY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start || auto_pend) begin
            state     <= S_CLEAR;
            idx       <= '0;
            auto_pend <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (clear_last) begin
            state <= S_LOAD;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_LOAD: begin
          if (tab_last) begin
`ifdef DM_BOOT_VERIFY_EN
            state <= S_VERIFY;
`else
            state <= S_DONE;
`endif
            idx <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
`ifdef DM_BOOT_VERIFY_EN
        S_VERIFY: begin
          if (rd != DATA_W'(tab_data)) begin
            err_q <= 1'b1;
            state <= S_ERROR;
          end else if (tab_last) begin
            state <= S_DONE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_ERROR: begin
          if (start) begin
            err_q <= 1'b0;
            state <= S_CLEAR;
            idx   <= '0;
          end
        end
`endif
        S_DONE: begin
          if (start) begin
            state <= S_CLEAR;
            idx   <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Moore output decode of state/idx.
  always_comb begin
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    a        = '0;
    wd       = '0;
    busy     = 1'b0;
    done     = 1'b0;
    cpu_hold = 1'b1;
    case (state)
      S_CLEAR: begin
        MemWrite = 1'b1;
        a        = DM_ADDRESS'(idx32);
        busy     = 1'b1;
      end
      S_LOAD: begin
        MemWrite = 1'b1;
        a        = DM_ADDRESS'(tab_addr);
        wd       = DATA_W'(tab_data);
        busy     = 1'b1;
      end
`ifdef DM_BOOT_VERIFY_EN
      S_VERIFY: begin
        MemRead = 1'b1;
        a       = DM_ADDRESS'(tab_addr);
        busy    = 1'b1;
      end
`endif
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      default: begin
        MemRead = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/dm_boot_loader.md
Name: dm_boot_loader

Overview:
- Write-side initiator for the single-port data memory. Drives the memory's MemRead/MemWrite/a/wd port and reads rd.
- After reset, or on a start pulse, it zeroes a low address window and then writes a fixed constant table into the data memory.
- Holds the CPU (cpu_hold) until loading completes, which removes the ADDI/SW initialisation prologue from the program.
- Sits between the core's memory port and the data memory via an external mux selected by cpu_hold.

Parameters:
- DM_ADDRESS, 9, data memory address width.
- DATA_W, 32, data word width.
- CLEAR_WORDS, 20, number of words zeroed (addresses 0..CLEAR_WORDS-1); must be ≥1 and ≤2**DM_ADDRESS.
- AUTO_START, 1, 1 = begin loading on the first cycle after reset; 0 = wait for start.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; honoured only in IDLE or DONE.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable; the memory writes on the next rising edge.
- a  output  DM_ADDRESS  memory address.
- wd  output  DATA_W  write data.
- rd  input  DATA_W  memory read data (combinational from a while MemRead=1).
- busy  output  1  high in CLEAR/LOAD/VERIFY.
- done  output  1  high in DONE.
- cpu_hold  output  1  high in every state except DONE.
- error  output  1  verify mismatch flag (tied 0 without DM_BOOT_VERIFY_EN).

Behaviour:
- States: IDLE, CLEAR, LOAD, VERIFY, DONE, ERROR.
- Registers: state, idx (index counter, width to cover max(CLEAR_WORDS, NUM_ENTRIES)), error.
- Reset (synchronous): state=IDLE, idx=0, error=0. Resulting outputs: MemRead=0, MemWrite=0, a=0, wd=0, busy=0, done=0, cpu_hold=1. Reset in any state aborts immediately, with no further writes in the following cycle.
- Outputs are a Moore decode of state/idx and are valid for the whole cycle. All outputs other than those listed per state are 0.
- Constant table, NUM_ENTRIES=5, entry index → (addr, data):
  - 0 → (4, 0x00000005)
  - 1 → (8, 0xFFFFFFF7)
  - 2 → (12, 0x0000000C)
  - 3 → (13, 0x0000000E)
  - 4 → (14, 0xFFFFFFEE)
  - Table addresses are truncated to DM_ADDRESS bits.
- IDLE → CLEAR with idx=0 when start=1 or (AUTO_START=1 and this is the first IDLE cycle after reset).
- CLEAR: MemWrite=1, a=idx, wd=0, busy=1.
  - idx increments each cycle.
  - At idx=CLEAR_WORDS-1 → LOAD with idx=0.
- LOAD: MemWrite=1, a=table_addr(idx), wd=table_data(idx), busy=1.
  - At idx=NUM_ENTRIES-1 → VERIFY (macro defined) or DONE.
  - Table entries overwrite zeroed words because LOAD follows CLEAR.
- DONE: done=1, cpu_hold=0, bus idle. start=1 → CLEAR with idx=0 (re-initialise).
- start while busy is ignored, with no queuing.
- MemRead and MemWrite are never both 1.
- Latency with defaults: start sampled at edge E0 → CLEAR cycles 1–20, LOAD cycles 21–25, done=1 from cycle 26. Total busy = CLEAR_WORDS+NUM_ENTRIES cycles (+NUM_ENTRIES with verify).
- Boundary: CLEAR_WORDS=1 gives a single CLEAR cycle at address 0.

Optional Feature:
- Macro: DM_BOOT_VERIFY_EN.
- Defined: VERIFY state follows LOAD.
  - Each cycle: MemRead=1, MemWrite=0, a=table_addr(idx), busy=1; rd is compared against table_data(idx) in the same cycle.
  - Mismatch: error←1, → ERROR.
  - Match at idx=NUM_ENTRIES-1 → DONE.
  - ERROR: error=1, cpu_hold=1, done=0, busy=0, bus idle. Left only by reset or start (start clears error and → CLEAR).
- Not defined: VERIFY and ERROR states are absent, LOAD → DONE, error is tied 0.

Test Plan:
- AUTO_START=1, reset high 2 cycles then low → 20 writes with a=0..19, wd=0, then writes to 4,8,12,13,14 with 5,-9,12,14,-18; done=1 and cpu_hold=0 in cycle 26; memory model word 12 = 12.
- AUTO_START=0 → stays IDLE with cpu_hold=1 for 50 cycles; start pulse → same sequence, done 26 cycles after start.
- start pulsed during CLEAR at idx=7 → ignored; sequence length unchanged; in DONE, start → full reload, word 8 restored to 0xFFFFFFF7 after the CPU wrote 0.
- reset asserted during LOAD at idx=2 → next cycle MemWrite=0, state IDLE; with AUTO_START=1 the reload completes normally.
- DM_BOOT_VERIFY_EN defined, memory model forces word 13 to read 0 → error=1 in ERROR, cpu_hold stays 1, done=0; healthy memory → done in cycle 31, error=0.
- Throughout all runs: assert never (MemRead && MemWrite), and assert a < 2**DM_ADDRESS.
